int8_packer: RTL and testbench

Downstream neighbour of the requantizer. Accepts a stream of saturated signed int8 results, one per cycle, and packs LANES consecutive bytes into one output word. Packed words are buffered in a small FIFO and emitted on a valid/ready interface toward the output SRAM writer. A `last` marker flushes a partial word with a byte strobe, so tile ends need not align to LANES.

---
 rtl/int8_packer_pkg.sv | 20 ++
 rtl/int8_packer_sync_fifo.sv | 55 +++++
 rtl/int8_packer.sv | 91 +++++++++
 tb/tb_int8_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int8_packer_pkg.sv
// rtl/int8_packer_pkg.sv - shared types and defaults for the int8 packing output stage
package int8_packer_pkg;

   // Default geometry of the packer and its output queue
   localparam int DEFAULT_LANES = 4;
   localparam int DEFAULT_DEPTH = 4;

   // One packed output word as it sits in the queue: bytes, byte strobe, tile-end marker
   typedef struct packed {
      logic [8*DEFAULT_LANES-1:0] data;
      logic [DEFAULT_LANES-1:0]   strb;
      logic                       last;
   } packed_word_t;

   // Flattened width of a packed word for a given lane count
   function automatic int word_bits(input int lanes);
      return 9 * lanes + 1;
   endfunction

endpackage

// File: rtl/int8_packer_sync_fifo.sv
// rtl/int8_packer_sync_fifo.sv - synchronous word FIFO with extra-bit wrap pointers
module sync_fifo
   import int8_packer_pkg::*;
#(
   parameter int WIDTH = word_bits(DEFAULT_LANES),
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The pointer MSB tells a full queue apart from an empty one at equal low bits
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Read and write pointers advance independently, so push+pop keeps occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/int8_packer.sv
// rtl/int8_packer.sv - packs a stream of int8 results into LANES-byte words with byte strobes
module int8_packer
   import int8_packer_pkg::*;
#(
   parameter int LANES = DEFAULT_LANES,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [7:0]         in_data_i,
   input  logic               in_last_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [8*LANES-1:0] out_data_o,
   output logic [LANES-1:0]   out_strb_o,
   output logic               out_last_o
);

   localparam int LW = $clog2(LANES);
   localparam int WW = word_bits(LANES);

   logic [LW-1:0]      lane_q;
   logic [8*LANES-1:0] data_q;
   logic [8*LANES-1:0] data_next;
   logic [LANES-1:0]   strb_q;
   logic [LANES-1:0]   strb_next;
   logic               accept;
   logic               complete;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [WW-1:0]      push_word;
   logic [WW-1:0]      head_word;

   // Ready comes from queue state only; a full queue blocks even while it is draining
   assign in_ready_o = !fifo_full && !rst_i;
   assign accept     = in_valid_i && in_ready_o;
   assign complete   = accept && ((lane_q == LW'(LANES-1)) || in_last_i);

   // Merge the incoming byte into the partial word at the current lane
   always_comb begin
      data_next = data_q;
      strb_next = strb_q;
      for (int k = 0; k < LANES; k++) begin
         if (lane_q == LW'(k)) begin
            data_next[8*k +: 8] = in_data_i;
            strb_next[k]        = 1'b1;
         end
      end
      push_word = {data_next, strb_next, in_last_i};
   end

   // Assembly register: advance the lane, or clear after handing the word to the queue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else if (complete) begin
         lane_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else if (accept) begin
         lane_q <= lane_q + LW'(1);
         data_q <= data_next;
         strb_q <= strb_next;
      end
   end

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (complete),
      .wdata (push_word),
      .pop   (pop),
      .rdata (head_word),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Outputs read as zero whenever no word is presented, including during reset
   assign out_valid_o = !fifo_empty && !rst_i;
   assign pop         = out_valid_o && out_ready_i;
   assign {out_data_o, out_strb_o, out_last_o} = out_valid_o ? head_word : '0;

endmodule

// File: tb/tb_int8_packer.sv
// tb/tb_int8_packer.sv - self-checking bench for int8_packer against a queue-level model
module tb_int8_packer;
   import int8_packer_pkg::*;

   localparam int LANES = 4;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [7:0]        in_data = 8'h00;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [8*LANES-1:0] out_data;
   logic [LANES-1:0]  out_strb;
   logic              out_last;

   int checks = 0;
   int errors = 0;

   packed_word_t exp_q[$];
   logic [7:0]   part_q[$];

   int8_packer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_strb_o  (out_strb),
      .out_last_o  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   // Model: a word is the list of bytes collected until LANES bytes or a last marker
   always @(negedge clk) begin
      packed_word_t w;
      logic exp_ready;
      logic exp_valid;
      if (rst) begin
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_out_data", out_data, 32'd0);
         check("rst_out_strb", {28'd0, out_strb}, 32'd0);
         exp_q.delete();
         part_q.delete();
      end else begin
         exp_ready = (exp_q.size() < DEPTH);
         exp_valid = (exp_q.size() > 0);
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
         if (exp_valid) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_strb", {28'd0, out_strb}, {28'd0, exp_q[0].strb});
            check("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
            if (out_ready) void'(exp_q.pop_front());
         end else begin
            check("idle_data", out_data, 32'd0);
         end
         if (in_valid && exp_ready) begin
            part_q.push_back(in_data);
            if (part_q.size() == LANES || in_last) begin
               w = '0;
               for (int i = 0; i < part_q.size(); i++) begin
                  w.data[8*i +: 8] = part_q[i];
                  w.strb[i]        = 1'b1;
               end
               w.last = in_last;
               exp_q.push_back(w);
               part_q.delete();
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int  budget;
      logic acc;
      budget   = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         budget++;
         if (!acc && budget > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got stalled want accepted at %0t", $time);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      logic [31:0] want;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pin_rst_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("pin_ready_after_rst", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Full word, one cycle latency
      out_ready = 1'b1;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b1);
      @(negedge clk);
      check("pin_full_valid", {31'd0, out_valid}, 32'd1);
      check("pin_full_data", out_data, 32'h04030201);
      check("pin_full_strb", {28'd0, out_strb}, 32'hF);
      check("pin_full_last", {31'd0, out_last}, 32'd1);
      @(posedge clk); #1;

      // Partial flush, then next byte starts at lane 0
      send(8'h7F, 1'b0);
      send(8'h80, 1'b1);
      @(negedge clk);
      check("pin_part_data", out_data, 32'h0000807F);
      check("pin_part_strb", {28'd0, out_strb}, 32'h3);
      check("pin_part_last", {31'd0, out_last}, 32'd1);
      @(posedge clk); #1;
      send(8'h55, 1'b1);
      @(negedge clk);
      check("pin_lane0_data", out_data, 32'h00000055);
      check("pin_lane0_strb", {28'd0, out_strb}, 32'h1);
      @(posedge clk); #1;

      // Backpressure: 16 bytes fill the queue, then drain in order
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
      @(negedge clk);
      check("pin_bp_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         want = {8'(8'h13 + 4*k), 8'(8'h12 + 4*k), 8'(8'h11 + 4*k), 8'(8'h10 + 4*k)};
         @(negedge clk);
         check("pin_drain_data", out_data, want);
      end
      @(negedge clk);
      check("pin_drain_empty", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Simultaneous push and pop with three words queued
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) send(8'(8'h20 + i), 1'b0);
      out_ready = 1'b1;
      send(8'h2F, 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      check("pin_pp_head", out_data, 32'h27262524);
      check("pin_pp_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Reset mid-tile with one word queued
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("pin_rst_mid_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("pin_post_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'h41, 1'b0);
      send(8'h42, 1'b0);
      send(8'h43, 1'b0);
      send(8'h44, 1'b1);
      @(negedge clk);
      check("pin_clean_data", out_data, 32'h44434241);
      check("pin_clean_strb", {28'd0, out_strb}, 32'hF);
      @(posedge clk); #1;
      @(negedge clk);
      check("pin_one_word", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Stability of a stalled head
      out_ready = 1'b0;
      send(8'hA5, 1'b0);
      send(8'h5A, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("pin_hold_data", out_data, 32'h00005AA5);
         check("pin_hold_strb", {28'd0, out_strb}, 32'h3);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic checked by the model every cycle
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_last   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
